systolic_requant_drain: RTL
===========================

SYSTOLIC_REQUANT_DRAIN -- requirements
Module: systolic_requant_drain

Interface
REQ-001 SHALL have parameter ROWS, default 4, tile rows.
REQ-002 SHALL have parameter COLS, default 4, tile columns.
REQ-003 SHALL have parameter ACCW, default 32, accumulator width.
REQ-004 SHALL have parameter OW, default 8, output element width.
REQ-005 SHALL have port clk  in  1  single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port tile_valid  in  1  one-cycle tile-complete pulse from the array's done output.
REQ-008 SHALL have port tile_data  in  ROWS*COLS*ACCW  signed accumulators; element (r,c) is at bits [(r*COLS+c)*ACCW +: ACCW].
REQ-009 SHALL have port shift_amt  in  5  right-shift for requantisation.
REQ-010 SHALL have port relu_en  in  1  clamp negative values to 0.
REQ-011 SHALL have port tile_ready  out  1  capture buffer free.
REQ-012 SHALL have port out_valid  out  1  output row beat valid.
REQ-013 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-014 SHALL have port out_data  out  COLS*OW  one requantised row; column c is at bits [c*OW +: OW].
REQ-015 SHALL have port out_row  out  clog2(ROWS)  index of the current row.
REQ-016 SHALL have port out_last  out  1  current beat is row ROWS-1.
REQ-017 SHALL have port sat_flag  out  1  at least one element of the current beat saturated.
REQ-018 SHALL have port drop_err  out  1  sticky flag: a tile was lost.

Function
REQ-019 SHALL use a two-state FSM: IDLE and DRAIN.
REQ-020 SHALL assert tile_ready in IDLE, and in DRAIN on a cycle where out_last, out_valid and out_ready are all high.
REQ-021 SHALL capture tile_data, shift_amt and relu_en when tile_valid and tile_ready are both high, then enter DRAIN with row counter 0.
REQ-022 SHALL hold the captured shift_amt and relu_en for the whole tile; input changes during DRAIN have no effect on that tile.
REQ-023 SHALL assert out_valid from the cycle after capture until the last beat is accepted.
REQ-024 SHALL advance the row counter only on an out_valid and out_ready handshake.
REQ-025 SHALL keep out_data, out_row, out_last and sat_flag stable while out_valid is high and out_ready is low.
REQ-026 SHALL derive out_data, out_row, out_last and sat_flag from registers only, with no combinational path from out_ready.
REQ-027 SHALL, on acceptance of the last beat:
- capture a new tile if tile_valid is high that cycle and stay in DRAIN at row 0 (back-to-back);
- otherwise return to IDLE.
REQ-028 SHALL, when tile_valid is high and tile_ready is low, discard the tile, set drop_err, and leave the drain in progress undisturbed.
REQ-029 SHALL compute each element in ACCW+1 bits, in this order:
- if relu_en and the value is negative, the value is 0;
- if shift_amt > 0, add 2^(shift_amt-1) (round half up);
- arithmetic right shift by shift_amt;
- saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-030 SHALL treat shift_amt = 0 as pass-through followed by saturation.
REQ-031 SHALL set sat_flag when any column of the current row was clipped by saturation.
REQ-032 SHALL hold drop_err high until reset.

Reset
REQ-033 SHALL, while rst is high, force:
- FSM to IDLE and row counter to 0;
- out_valid, out_data, out_row, out_last, sat_flag and drop_err to 0;
- capture buffer to 0;
- tile_ready to 1 once the FSM is in IDLE.
REQ-034 SHALL, when reset is asserted mid-drain, abandon the tile with no further beats.
REQ-035 SHALL leave the first capture after reset release unaffected by any pre-reset state.

Structure
REQ-036 SHALL take ROWS, COLS, ACCW, OW defaults and the FSM state type from shared package systolic_pkg.
REQ-037 SHALL implement per-element ReLU, rounding, shift and saturation in combinational sub-module requant_unit, instantiated COLS times.

Verification
REQ-038 SHALL cover basic drain: tile (r,c)=r*COLS+c, shift 0, relu off -> 4 beats, rows 0..3, row 2 = {8,9,10,11}, out_last on beat 3, sat_flag 0.
REQ-039 SHALL cover rounding and shift: element 0x00000180, shift 8 -> 2; element -384, shift 8 -> -1; element 127, shift 0 -> 127.
REQ-040 SHALL cover saturation and ReLU:
- relu off: 100000 -> 127 and -100000 -> -128, sat_flag 1;
- relu on: -100000 -> 0, sat_flag 0.
REQ-041 SHALL cover backpressure: out_ready low 5 cycles on beat 1 -> out_data/out_row held, no beat lost or duplicated.
REQ-042 SHALL cover back-to-back and drop:
- second tile_valid on the last-beat handshake -> next beat is row 0 of the new tile, drop_err 0;
- tile_valid during beat 1 -> drop_err 1, original 4 beats intact.
REQ-043 SHALL cover reset mid-operation: rst pulse during beat 2 -> out_valid 0 the same cycle, tile_ready 1, next tile drains normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg
//   Shared definitions for the systolic-array output path.
//   - *_DEF localparams : default tile geometry and element widths
//   - drain_state_t     : state type of the drain FSM
//   - row_w()           : width of a row index (at least 1 bit)
package systolic_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;
  localparam int ACCW_DEF = 32;
  localparam int OW_DEF   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/requant_unit.sv
// requant_unit
//   Combinational requantisation of one signed accumulator to OW bits.
//   Ports:
//     acc       in  ACCW  signed accumulator
//     shift_amt in  5     arithmetic right shift (0 = pass-through)
//     relu_en   in  1     force negative inputs to zero first
//     q         out OW    saturated, rounded, shifted result
//     sat       out 1     result was clipped to the OW range
//   All arithmetic is done in ACCW+1 bits so the rounding add cannot wrap.
module requant_unit #(
  parameter int ACCW = 32,
  parameter int OW   = 8
) (
  input  logic [ACCW-1:0] acc,
  input  logic [4:0]      shift_amt,
  input  logic            relu_en,
  output logic [OW-1:0]   q,
  output logic            sat
);

  localparam logic signed [ACCW:0] MAX_V =
    $signed({{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}});
  localparam logic signed [ACCW:0] MIN_V =
    $signed({{(ACCW-OW+2){1'b1}}, {(OW-1){1'b0}}});
  localparam logic signed [ACCW:0] ONE = (ACCW+1)'(1);

  logic signed [ACCW:0] v;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] sum;
  logic signed [ACCW:0] sh;

  always_comb begin
    v = $signed({acc[ACCW-1], acc});
    if (relu_en && (v < 0)) v = '0;

    // Round half up: add half an output LSB before truncating.
    rnd = '0;
    if (shift_amt != 5'd0) rnd = ONE << (shift_amt - 5'd1);
    sum = v + rnd;
    sh  = sum >>> shift_amt;

    sat = 1'b0;
    q   = sh[OW-1:0];
    if (sh > MAX_V) begin
      q   = MAX_V[OW-1:0];
      sat = 1'b1;
    end else if (sh < MIN_V) begin
      q   = MIN_V[OW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_requant_drain.sv
// systolic_requant_drain
//   Captures a finished ROWSxCOLS accumulator tile and drains it one
//   requantised row per beat.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     tile_valid/tile_ready tile capture handshake
//     tile_data             ROWS*COLS*ACCW signed accumulators, (r,c) at (r*COLS+c)*ACCW
//     shift_amt, relu_en    requant controls, latched with the tile
//     out_valid/out_ready   row beat handshake
//     out_data              COLS*OW requantised row, column c at c*OW
//     out_row, out_last     row index of the beat, beat is the last row
//     sat_flag              some column of this beat saturated
//     drop_err              sticky: a tile arrived while the buffer was busy
//     state_dbg             current FSM state
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and the beat
// payload stays stable while valid is high and ready is low. tile_ready does
// look at out_ready so a new tile can be taken on the final beat's handshake.
module systolic_requant_drain
  import systolic_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int OW   = OW_DEF,
  localparam int RW  = row_w(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tile_valid,
  input  logic [ROWS*COLS*ACCW-1:0] tile_data,
  input  logic [4:0]               shift_amt,
  input  logic                     relu_en,
  output logic                     tile_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*OW-1:0]       out_data,
  output logic [RW-1:0]            out_row,
  output logic                     out_last,
  output logic                     sat_flag,
  output logic                     drop_err,
  output drain_state_t             state_dbg
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  drain_state_t    state_q;
  logic [RW-1:0]   row_q;
  logic            out_valid_q;
  logic            drop_q;
  logic [4:0]      shift_q;
  logic            relu_q;
  logic [ACCW-1:0] buf_q [ROWS][COLS];

  logic            at_last;
  logic            last_accept;
  logic            capture;
  logic [COLS-1:0] sat_vec;

  assign at_last     = (row_q == LAST_ROW);
  assign last_accept = out_valid_q & out_ready & at_last;
  assign tile_ready  = (state_q == ST_IDLE) | last_accept;
  assign capture     = tile_valid & tile_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          buf_q[r][c] <= '0;
    end else begin
      if (tile_valid && !tile_ready) drop_q <= 1'b1;

      if (capture) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            buf_q[r][c] <= tile_data[(r*COLS+c)*ACCW +: ACCW];
        shift_q <= shift_amt;
        relu_q  <= relu_en;
      end

      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q     <= ST_DRAIN;
            row_q       <= '0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (at_last) begin
              row_q <= '0;
              // A tile offered on the final handshake keeps the drain going.
              if (!capture) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The beat payload is a function of the capture buffer, the latched
  // controls and the row counter only, so it cannot glitch with out_ready.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    requant_unit #(
      .ACCW(ACCW),
      .OW  (OW)
    ) u_rq (
      .acc      (buf_q[row_q][c]),
      .shift_amt(shift_q),
      .relu_en  (relu_q),
      .q        (out_data[c*OW +: OW]),
      .sat      (sat_vec[c])
    );
  end

  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign out_last  = out_valid_q & at_last;
  assign sat_flag  = |sat_vec;
  assign drop_err  = drop_q;
  assign state_dbg = state_q;

endmodule
